// File: rtl/pio_input.sv
// ---------------------------------------------------------------------------
// pio_input
//   Input-side PIO: the CPU read port for board switches and push-buttons.
//   Every raw input passes through a two-flop synchroniser. Buttons are then
//   debounced, and a debounced press sets a sticky pending bit that stays set
//   until the CPU reads the port.
//
// Ports
//   clk        in   1      system clock, all flops on posedge
//   rst        in   1      asynchronous reset, active-low
//   SW         in   N_SW   raw switch levels (asynchronous)
//   BTN        in   N_BTN  raw button levels (asynchronous, bouncy)
//   EN         in   1      CPU read strobe, one cycle per read
//   PData_out  out  32     read data: [15:0] switches, [20:16] debounced
//                          buttons, [25:21] pending presses, rest zero
//   IRQ        out  1      high while any pending bit is set
// ---------------------------------------------------------------------------
module pio_input #(
  parameter int N_SW      = 16,
  parameter int N_BTN     = 5,
  parameter int DEB_W     = 20,
  parameter int DEB_COUNT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  SW,
  input  logic [N_BTN-1:0] BTN,
  input  logic             EN,
  output logic [31:0]      PData_out,
  output logic             IRQ
);

  // Terminal count: the stable value flips on the edge where the counter
  // already holds this value, giving exactly DEB_COUNT disagreeing edges.
  localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEB_COUNT - 1);

  logic [N_SW-1:0]  swMeta_q;
  logic [N_SW-1:0]  swSync_q;
  logic [N_BTN-1:0] btnMeta_q;
  logic [N_BTN-1:0] btnSync_q;
  logic [N_BTN-1:0] btnStable_q;
  logic [N_BTN-1:0] btnStable_d;
  logic [N_BTN-1:0] pend_q;
  logic [N_BTN-1:0] pend_d;
  logic [DEB_W-1:0] cnt_q [N_BTN];
  logic [DEB_W-1:0] cnt_d [N_BTN];

  // Two-flop synchronisers for switches and buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swMeta_q  <= '0;
      swSync_q  <= '0;
      btnMeta_q <= '0;
      btnSync_q <= '0;
    end else begin
      swMeta_q  <= SW;
      swSync_q  <= swMeta_q;
      btnMeta_q <= BTN;
      btnSync_q <= btnMeta_q;
    end
  end

  // Debounce: a counter runs only while the synchronised level disagrees
  // with the accepted level; any agreement (a glitch ending) restarts it.
  always_comb begin
    btnStable_d = btnStable_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (btnSync_q[i] != btnStable_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          btnStable_d[i] = ~btnStable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  // A read clears every pending bit, but a press accepted on the same edge
  // is ORed in afterwards so it is never lost.
  always_comb begin
    pend_d = (EN ? '0 : pend_q) | (btnStable_d & ~btnStable_q);
  end

  // Debounce and pending state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnStable_q <= '0;
      pend_q      <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      btnStable_q <= btnStable_d;
      pend_q      <= pend_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Read data comes straight from registers, so the CPU sees the pre-clear
  // pending value during its EN cycle.
  always_comb begin
    PData_out = '0;
    PData_out[N_SW-1:0]    = swSync_q;
    PData_out[16 +: N_BTN] = btnStable_q;
    PData_out[21 +: N_BTN] = pend_q;
  end

  assign IRQ = |pend_q;

endmodule

// File: tb/tb_pio_input.sv
// ---------------------------------------------------------------------------
// tb_pio_input
//   Self-checking bench for pio_input with DEB_COUNT=4. A behavioural model
//   tracks, per button, how many consecutive edges the synchronised level has
//   disagreed with the accepted level; the compare process checks every
//   falling edge. Directed scenarios add literal expectations, followed by a
//   randomised phase.
// ---------------------------------------------------------------------------
module tb_pio_input;

  localparam int Deb = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] SW;
  logic [4:0]  BTN;
  logic        EN;
  logic [31:0] PData_out;
  logic        IRQ;

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  pio_input #(
    .N_SW(16), .N_BTN(5), .DEB_W(20), .DEB_COUNT(Deb)
  ) dut (
    .clk(clk), .rst(rst), .SW(SW), .BTN(BTN), .EN(EN),
    .PData_out(PData_out), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw samples ride a 2-deep history; a button's
  // accepted level follows its synchronised level once they have disagreed
  // for Deb consecutive edges; accepted rises are latched until a read.
  logic [15:0] mSwHist1 = '0, mSwHist2 = '0;
  logic [4:0]  mBtnHist1 = '0, mBtnHist2 = '0;
  logic [4:0]  mStable = '0, mPend = '0;
  int          mRun [5];
  logic [4:0]  rose;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mSwHist1 = '0; mSwHist2 = '0; mBtnHist1 = '0; mBtnHist2 = '0;
      mStable = '0; mPend = '0;
      for (int i = 0; i < 5; i++) mRun[i] = 0;
    end else begin
      rose = '0;
      for (int i = 0; i < 5; i++) begin
        if (mBtnHist2[i] != mStable[i]) begin
          mRun[i] = mRun[i] + 1;
          if (mRun[i] == Deb) begin
            mStable[i] = mBtnHist2[i];
            mRun[i] = 0;
            if (mStable[i]) rose[i] = 1'b1;
          end
        end else begin
          mRun[i] = 0;
        end
      end
      if (EN) mPend = '0;
      mPend = mPend | rose;
      mSwHist2 = mSwHist1;  mSwHist1 = SW;
      mBtnHist2 = mBtnHist1; mBtnHist1 = BTN;
    end
  end

  // Compare process: every falling edge once the DUT has seen a reset edge.
  always @(negedge clk) begin
    if (checkOn) begin
      logic [31:0] exp;
      exp = {6'b0, mPend, mStable, mSwHist2};
      total++;
      if (PData_out !== exp) begin
        bad++;
        $display("[TB] FAIL model PData_out: got %h expected %h at %0t", PData_out, exp, $time);
      end
      total++;
      if (IRQ !== (|mPend)) begin
        bad++;
        $display("[TB] FAIL model IRQ: got %b expected %b at %0t", IRQ, |mPend, $time);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; SW = 16'hFFFF; BTN = 5'h1F; EN = 1'b0;

    // Reset held with all inputs high
    applyStimulus(1);
    checkOn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset PData", PData_out, 32'h0);
      checkOutput("reset IRQ", {31'b0, IRQ}, 32'h0);
      applyStimulus(1);
    end
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("sw after 1 edge", {16'b0, PData_out[15:0]}, 32'h0);
    applyStimulus(1);
    checkOutput("sw after 2 edges", {16'b0, PData_out[15:0]}, 32'h0000_FFFF);

    // Quiet down and clear
    SW = 16'h0; BTN = 5'h0;
    applyStimulus(12);
    EN = 1'b1; applyStimulus(1); EN = 1'b0;
    applyStimulus(2);
    checkOutput("idle PData", PData_out, 32'h0);

    // Clean press on BTN[2]
    BTN[2] = 1'b1;
    applyStimulus(5);
    checkOutput("press 5 edges", PData_out, 32'h0);
    applyStimulus(1);
    checkOutput("press 6 edges", PData_out, 32'h0084_0000);
    checkOutput("press IRQ", {31'b0, IRQ}, 32'h1);

    // Bouncy BTN[0], then held
    BTN[0] = 1'b1; applyStimulus(2);
    BTN[0] = 1'b0; applyStimulus(2);
    BTN[0] = 1'b1; applyStimulus(2);
    BTN[0] = 1'b0; applyStimulus(2);
    BTN[0] = 1'b1;
    applyStimulus(5);
    checkOutput("bounce 5 edges pend", {27'b0, PData_out[25:21]}, 32'h4);
    applyStimulus(1);
    checkOutput("bounce 6 edges pend", {27'b0, PData_out[25:21]}, 32'h5);

    // Read-clear
    EN = 1'b1;
    checkOutput("read data pend", {27'b0, PData_out[25:21]}, 32'h5);
    applyStimulus(1);
    EN = 1'b0;
    checkOutput("after read pend", {27'b0, PData_out[25:21]}, 32'h0);
    checkOutput("after read IRQ", {31'b0, IRQ}, 32'h0);
    checkOutput("after read stable", {27'b0, PData_out[20:16]}, 32'h5);

    // Collision: BTN[1] accepted on the same edge as a read
    BTN[3] = 1'b1;
    applyStimulus(8);
    checkOutput("pend3 set", {27'b0, PData_out[25:21]}, 32'h8);
    BTN[1] = 1'b1;
    applyStimulus(5);
    EN = 1'b1;
    applyStimulus(1);
    EN = 1'b0;
    checkOutput("collision pend", {27'b0, PData_out[25:21]}, 32'h2);
    checkOutput("collision IRQ", {31'b0, IRQ}, 32'h1);

    // Release BTN[2]
    BTN[2] = 1'b0;
    applyStimulus(5);
    checkOutput("release 5 edges", {27'b0, PData_out[20:16]}, 32'hF);
    applyStimulus(1);
    checkOutput("release 6 edges", {27'b0, PData_out[20:16]}, 32'hB);
    checkOutput("release no pend", {27'b0, PData_out[25:21]}, 32'h2);
    EN = 1'b1; applyStimulus(1); EN = 1'b0;

    // Reset mid-count on BTN[4]
    BTN[4] = 1'b1;
    applyStimulus(3);
    rst = 1'b0;
    #1;
    checkOutput("mid reset PData", PData_out, 32'h0);
    applyStimulus(2);
    rst = 1'b1;
    applyStimulus(5);
    checkOutput("post reset 5 edges", {27'b0, PData_out[25:21]}, 32'h0);
    applyStimulus(1);
    checkOutput("post reset 6 edges", {27'b0, PData_out[25:21]}, 32'h1B);
    BTN = 5'h0;
    applyStimulus(10);
    checkOutput("no spurious pend", {27'b0, PData_out[25:21]}, 32'h1B);
    checkOutput("all released", {27'b0, PData_out[20:16]}, 32'h0);

    // Randomised phase
    for (int seg = 0; seg < 400; seg++) begin
      int hold;
      hold = $urandom_range(1, 9);
      BTN = BTN ^ 5'($urandom & $urandom);
      SW  = 16'($urandom);
      if ($urandom_range(0, 99) == 0) rst = 1'b0;
      for (int c = 0; c < hold; c++) begin
        EN = ($urandom_range(0, 3) == 0);
        applyStimulus(1);
      end
      rst = 1'b1;
    end
    EN = 1'b0;
    applyStimulus(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
